// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit CPU: instruction field positions,
// opcode constants and the fetch-stage state encoding.
package cpu_pkg;

    localparam int INSTR_W = 24;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 23;
    localparam int OPCODE_LSB = 20;
    localparam int RS_MSB     = 19;
    localparam int RS_LSB     = 16;
    localparam int RT_MSB     = 15;
    localparam int RT_LSB     = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 8;
    localparam int IMM_MSB    = 11;
    localparam int IMM_LSB    = 0;

    // Opcodes decoded by the control unit; OP_NOP is what an empty IF/ID reads as
    localparam logic [3:0] OP_RTYPE = 4'b0110;
    localparam logic [3:0] OP_LS    = 4'b0010;
    localparam logic [3:0] OP_SS    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_NOP   = 4'b0000;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetchState_t;

    // 12-bit immediate field sign-extended to the full instruction width
    function automatic logic [INSTR_W-1:0] signExtImm(input logic [INSTR_W-1:0] instr);
        return {{(INSTR_W - 12){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer. Holds the live
// instruction, its PC+1, and splits it into the fields the decoder needs.
// An empty register holds all zeros so every field reads as a NOP.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = 24
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               flush,
    input  logic               loadDirect,
    input  logic               captureSkid,
    input  logic               loadFromSkid,
    input  logic               drain,
    input  logic [INSTR_W-1:0] memWord,
    input  logic [PC_W-1:0]    memPcPlus1,
    output logic               idValid,
    output logic [PC_W-1:0]    idPcPlus1,
    output logic [3:0]         opcode,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [3:0]         rd,
    output logic [INSTR_W-1:0] imm
);

    logic [INSTR_W-1:0] instrReg;
    logic [INSTR_W-1:0] skidWord;
    logic [PC_W-1:0]    skidPcPlus1;
    logic               skidValid;

    // IF/ID update: flush beats a fresh load, which beats a skid drain, which beats a bubble
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            idValid   <= 1'b0;
            instrReg  <= '0;
            idPcPlus1 <= '0;
        end else if (flush) begin
            idValid   <= 1'b0;
            instrReg  <= '0;
            idPcPlus1 <= '0;
        end else if (loadDirect) begin
            idValid   <= 1'b1;
            instrReg  <= memWord;
            idPcPlus1 <= memPcPlus1;
        end else if (loadFromSkid && skidValid) begin
            idValid   <= 1'b1;
            instrReg  <= skidWord;
            idPcPlus1 <= skidPcPlus1;
        end else if (drain) begin
            idValid   <= 1'b0;
            instrReg  <= '0;
            idPcPlus1 <= '0;
        end
    end

    // Skid buffer: parks a word acked while IF/ID is frozen so it is never lost
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            skidValid   <= 1'b0;
            skidWord    <= '0;
            skidPcPlus1 <= '0;
        end else if (flush) begin
            skidValid <= 1'b0;
        end else if (captureSkid) begin
            skidValid   <= 1'b1;
            skidWord    <= memWord;
            skidPcPlus1 <= memPcPlus1;
        end else if (loadFromSkid) begin
            skidValid <= 1'b0;
        end
    end

    assign opcode = instrReg[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instrReg[RS_MSB:RS_LSB];
    assign rt     = instrReg[RT_MSB:RT_LSB];
    assign rd     = instrReg[RD_MSB:RD_LSB];
    assign imm    = signExtImm(instrReg);

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory request
// FSM and feeds the IF/ID register. Branch redirects and hazard stalls are
// resolved here.
//
// Memory handshake: ImemReq is held high with ImemAddr stable until a cycle
// in which ImemReq and ImemAck are both high; that cycle is the transfer and
// ImemRdata is valid in it. A request is never withdrawn mid-wait except by
// a redirect or reset.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 24,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    output logic               ImemReq,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemRdata,
    output logic               IdValid,
    output logic [PC_W-1:0]    IdPcPlus1,
    output logic [3:0]         Opcode,
    output logic [3:0]         Rs,
    output logic [3:0]         Rt,
    output logic [3:0]         Rd,
    output logic [INSTR_W-1:0] Imm,
    output logic [1:0]         DbgState
);

    fetchState_t     state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcPlus1;
    logic            xfer;
    logic            canAccept;

    assign pcPlus1   = pc + PC_W'(1);
    assign xfer      = ImemReq && ImemAck;
    assign canAccept = !Stall || !IdValid;
    assign ImemAddr  = pc;
    assign DbgState  = state;

    // Fetch FSM and PC: redirect first, then the per-state request handling
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= FS_IDLE;
            pc      <= RESET_PC;
            ImemReq <= 1'b0;
        end else if (BranchTaken) begin
            state   <= FS_FETCH;
            pc      <= BranchTarget;
            ImemReq <= 1'b1;
        end else begin
            case (state)
                FS_IDLE: begin
                    state   <= FS_FETCH;
                    ImemReq <= 1'b1;
                end
                FS_FETCH: begin
                    if (xfer) begin
                        pc <= pcPlus1;
                        if (!canAccept) begin
                            state   <= FS_HOLD;
                            ImemReq <= 1'b0;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!Stall) begin
                        state   <= FS_FETCH;
                        ImemReq <= 1'b1;
                    end
                end
                default: begin
                    state   <= FS_IDLE;
                    ImemReq <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_W(PC_W)
    ) u_ifId (
        .clock       (Clock),
        .resetN      (ResetN),
        .flush       (BranchTaken),
        .loadDirect  (xfer && canAccept),
        .captureSkid (xfer && !canAccept),
        .loadFromSkid(state == FS_HOLD && !Stall),
        .drain       (!Stall),
        .memWord     (ImemRdata),
        .memPcPlus1  (pcPlus1),
        .idValid     (IdValid),
        .idPcPlus1   (IdPcPlus1),
        .opcode      (Opcode),
        .rs          (Rs),
        .rt          (Rt),
        .rd          (Rd),
        .imm         (Imm)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios followed by random
// stall/branch/ack traffic, checked every cycle against a queue-based model
// of the fetch stream.
module tb_instr_fetch_stage;

  logic        clock;
  logic        resetN;
  logic        stall;
  logic        branchTaken;
  logic [23:0] branchTarget;
  logic        imemReq;
  logic [23:0] imemAddr;
  logic        ack;
  logic [23:0] imemRdata;
  logic        idValid;
  logic [23:0] idPcPlus1;
  logic [3:0]  opcode;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [3:0]  rd;
  logic [23:0] imm;
  logic [1:0]  dbgState;

  int nCompared = 0;
  int nMismatched = 0;

  instr_fetch_stage dut (
    .Clock       (clock),
    .ResetN      (resetN),
    .Stall       (stall),
    .BranchTaken (branchTaken),
    .BranchTarget(branchTarget),
    .ImemReq     (imemReq),
    .ImemAddr    (imemAddr),
    .ImemAck     (ack),
    .ImemRdata   (imemRdata),
    .IdValid     (idValid),
    .IdPcPlus1   (idPcPlus1),
    .Opcode      (opcode),
    .Rs          (rs),
    .Rt          (rt),
    .Rd          (rd),
    .Imm         (imm),
    .DbgState    (dbgState)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- memory contents ----------------
  function automatic logic [23:0] memWord(input logic [23:0] a);
    logic [23:0] p;
    if (a == 24'd0) return 24'h612345;
    p = a * 24'h0B3C1D;
    return p ^ 24'h5A5A5A;
  endfunction

  assign imemRdata = memWord(imemAddr);

  // ---------------- reference model ----------------
  // The fetch stream: words that have been handshaken but not yet delivered
  // wait in heldQ; a request is outstanding whenever nothing is waiting.
  logic        mReq = 1'b0;
  logic [23:0] mAddr = 24'd0;
  logic        mValid = 1'b0;
  logic [23:0] mWord = 24'd0;
  logic [23:0] mPcp1 = 24'd0;
  logic [47:0] heldQ[$];

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mReq = 1'b0;
      mAddr = 24'd0;
      mValid = 1'b0;
      mWord = 24'd0;
      mPcp1 = 24'd0;
      heldQ.delete();
    end else if (branchTaken) begin
      mReq = 1'b1;
      mAddr = branchTarget;
      mValid = 1'b0;
      mWord = 24'd0;
      mPcp1 = 24'd0;
      heldQ.delete();
    end else begin
      if (mReq && ack) begin
        heldQ.push_back({memWord(mAddr), mAddr + 24'd1});
        mAddr = mAddr + 24'd1;
      end
      if (!stall || !mValid) begin
        if (heldQ.size() != 0) begin
          {mWord, mPcp1} = heldQ.pop_front();
          mValid = 1'b1;
        end else begin
          mValid = 1'b0;
          mWord = 24'd0;
          mPcp1 = 24'd0;
        end
      end
      mReq = (heldQ.size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [47:0] actual, input logic [47:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    logic [23:0] w;
    w = mValid ? mWord : 24'd0;
    check("imemReq", 48'(imemReq), 48'(mReq));
    check("imemAddr", 48'(imemAddr), 48'(mAddr));
    check("idValid", 48'(idValid), 48'(mValid));
    check("opcode", 48'(opcode), 48'(w[23:20]));
    check("rs", 48'(rs), 48'(w[19:16]));
    check("rt", 48'(rt), 48'(w[15:12]));
    check("rd", 48'(rd), 48'(w[11:8]));
    check("imm", 48'(imm), 48'({{12{w[11]}}, w[11:0]}));
    if (mValid) check("idPcPlus1", 48'(idPcPlus1), 48'(mPcp1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] w1;
    resetN = 1'b1;
    stall = 1'b0;
    branchTaken = 1'b0;
    branchTarget = 24'd0;
    ack = 1'b1;
    #1 resetN = 1'b0;

    // Zero-wait memory out of reset
    repeat (3) tick();
    resetN = 1'b1;
    #1;
    check("reqInReset", 48'(imemReq), 48'd0);
    check("stateIdle", 48'(dbgState), 48'd0);
    tick();
    check("firstReq", 48'(imemReq), 48'd1);
    check("firstAddr", 48'(imemAddr), 48'd0);
    check("idleNoValid", 48'(idValid), 48'd0);
    tick();
    check("zwOpcode", 48'(opcode), 48'h6);
    check("zwRs", 48'(rs), 48'h1);
    check("zwRt", 48'(rt), 48'h2);
    check("zwRd", 48'(rd), 48'h3);
    check("zwImm", 48'(imm), 48'h000345);
    check("zwPcp1", 48'(idPcPlus1), 48'd1);
    check("zwAddr1", 48'(imemAddr), 48'd1);
    check("modelWord0", 48'(mWord), 48'h612345);
    tick();
    check("zwAddr2", 48'(imemAddr), 48'd2);
    check("zwPcp2", 48'(idPcPlus1), 48'd2);

    // Ack delayed 3 cycles after redirect to 0
    ack = 1'b0;
    branchTaken = 1'b1;
    branchTarget = 24'd0;
    tick();
    branchTaken = 1'b0;
    check("dlyFlush", 48'(idValid), 48'd0);
    check("dlyAddr", 48'(imemAddr), 48'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dlyAddrHeld", 48'(imemAddr), 48'd0);
      check("dlyNoValid", 48'(idValid), 48'd0);
      check("dlyReqHeld", 48'(imemReq), 48'd1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("dlyValid", 48'(idValid), 48'd1);
    check("dlyOpcode", 48'(opcode), 48'h6);

    // Stall in the same cycle as an ack with IdValid=1
    ack = 1'b1;
    stall = 1'b1;
    tick();
    check("holdState", 48'(dbgState), 48'd2);
    check("holdReqLow", 48'(imemReq), 48'd0);
    check("holdOpcodeKept", 48'(opcode), 48'h6);
    check("holdAddr", 48'(imemAddr), 48'd2);
    tick();
    check("holdReqLow2", 48'(imemReq), 48'd0);
    stall = 1'b0;
    tick();
    w1 = memWord(24'd1);
    check("skidOpcode", 48'(opcode), 48'(w1[23:20]));
    check("skidPcp1", 48'(idPcPlus1), 48'd2);
    check("skidReq", 48'(imemReq), 48'd1);
    check("skidAddr", 48'(imemAddr), 48'd2);
    tick();
    check("noSkipPcp1", 48'(idPcPlus1), 48'd3);

    // Redirect coinciding with an ack
    branchTaken = 1'b1;
    branchTarget = 24'h000040;
    tick();
    branchTaken = 1'b0;
    check("brFlush", 48'(idValid), 48'd0);
    check("brOpcode", 48'(opcode), 48'd0);
    check("brAddr", 48'(imemAddr), 48'h40);
    tick();
    check("brFirstPcp1", 48'(idPcPlus1), 48'h41);

    // PC wrap
    ack = 1'b0;
    branchTaken = 1'b1;
    branchTarget = 24'hFFFFFF;
    tick();
    branchTaken = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("wrapAddr", 48'(imemAddr), 48'd0);
    check("wrapPcp1", 48'(idPcPlus1), 48'd0);
    check("wrapValid", 48'(idValid), 48'd1);

    // Reset pulse during a pending request
    tick();
    check("pendingReq", 48'(imemReq), 48'd1);
    resetN = 1'b0;
    #1;
    check("asyncReq", 48'(imemReq), 48'd0);
    check("asyncAddr", 48'(imemAddr), 48'd0);
    check("asyncValid", 48'(idValid), 48'd0);
    check("asyncState", 48'(dbgState), 48'd0);
    tick();
    tick();
    resetN = 1'b1;
    ack = 1'b1;
    tick();
    check("restartAddr", 48'(imemAddr), 48'd0);
    check("restartReq", 48'(imemReq), 48'd1);
    tick();
    check("restartOpcode", 48'(opcode), 48'h6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      branchTaken = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        branchTarget = 24'hFFFFFD + 24'($urandom_range(0, 2));
      else
        branchTarget = 24'($urandom_range(0, 32'h00FFFFFF));
      ack = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 499) == 0) begin
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
      end
      tick();
    end

    stall = 1'b0;
    branchTaken = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
